// File: rtl/aemb2_fsl_link.sv
// FSL channel pair on the shared cwb coprocessor bus: PUT words drain to the fso_*
// stream, fsi_* words are collected for GET, each direction through its own FIFO.
module aemb2_fsl_link #(
  parameter int CHN = 0,
  parameter int AW  = 2
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [4:0]  cwb_adr_i,
  input  logic [1:0]  cwb_tga_i,
  input  logic        cwb_stb_i,
  input  logic        cwb_wre_i,
  input  logic [3:0]  cwb_sel_i,
  input  logic [31:0] cwb_dat_i,
  output logic [31:0] cwb_dat_o,
  output logic        cwb_ack_o,
  output logic [31:0] fso_dat_o,
  output logic        fso_ctl_o,
  output logic        fso_vld_o,
  input  logic        fso_rdy_i,
  input  logic [31:0] fsi_dat_i,
  input  logic        fsi_ctl_i,
  input  logic        fsi_vld_i,
  output logic        fsi_rdy_o,
  output logic        fsl_err_o
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [4:0]  CHN_SEL = 5'(CHN);

  logic [32:0]   tx_mem [DEPTH];
  logic [32:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;

  logic hit, nb, tx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic put_ack, get_ack;
  logic [32:0] tx_head, rx_head;

  // Byte lanes carry no meaning here; every access is a full word.
  logic unused_sel;
  assign unused_sel = ^cwb_sel_i;

  assign hit      = cwb_stb_i & (cwb_adr_i == CHN_SEL) & ~cwb_ack_o;
  assign nb       = cwb_tga_i[0];
  assign tx_full  = (tx_cnt == FULL);
  assign rx_empty = (rx_cnt == '0);

  assign tx_push = hit & cwb_wre_i & ~tx_full;
  assign put_ack = hit & cwb_wre_i & (nb | ~tx_full);
  assign rx_pop  = hit & ~cwb_wre_i & ~rx_empty;
  assign get_ack = hit & ~cwb_wre_i & (nb | ~rx_empty);

  assign tx_head = tx_mem[tx_rp];
  assign rx_head = rx_mem[rx_rp];

  // Stream handshakes are forced idle while reset is held.
  assign fso_vld_o = sys_rst_i & (tx_cnt != '0);
  assign fso_dat_o = tx_head[31:0];
  assign fso_ctl_o = tx_head[32];
  assign fsi_rdy_o = sys_rst_i & (rx_cnt != FULL);

  assign tx_pop  = fso_vld_o & fso_rdy_i;
  assign rx_push = fsi_vld_i & fsi_rdy_o;

  always_ff @(posedge sys_clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= {cwb_tga_i[1], cwb_dat_i};
    if (rx_push) rx_mem[rx_wp] <= {fsi_ctl_i, fsi_dat_i};
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      cwb_ack_o <= 1'b0;
      cwb_dat_o <= '0;
      fsl_err_o <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase

      cwb_ack_o <= put_ack | get_ack;
      // Non-blocking GET on an empty FIFO returns zero; cwb_dat_o otherwise holds.
      if (get_ack) cwb_dat_o <= rx_pop ? rx_head[31:0] : '0;
      fsl_err_o <= rx_pop & (rx_head[32] != cwb_tga_i[1]);
    end
  end

endmodule

// File: tb/tb_aemb2_fsl_link.sv
// Directed bench for aemb2_fsl_link (CHN=3, AW=2) with immediate-assertion checks.
module tb_aemb2_fsl_link;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [1:0]  tga;
  logic        stb, wre;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic [31:0] fso_dat;
  logic        fso_ctl, fso_vld, fso_rdy;
  logic [31:0] fsi_dat;
  logic        fsi_ctl, fsi_vld, fsi_rdy;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  aemb2_fsl_link #(.CHN(3), .AW(2)) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .cwb_adr_i(adr),
    .cwb_tga_i(tga),
    .cwb_stb_i(stb),
    .cwb_wre_i(wre),
    .cwb_sel_i(sel),
    .cwb_dat_i(wdat),
    .cwb_dat_o(rdat),
    .cwb_ack_o(ack),
    .fso_dat_o(fso_dat),
    .fso_ctl_o(fso_ctl),
    .fso_vld_o(fso_vld),
    .fso_rdy_i(fso_rdy),
    .fsi_dat_i(fsi_dat),
    .fsi_ctl_i(fsi_ctl),
    .fsi_vld_i(fsi_vld),
    .fsi_rdy_o(fsi_rdy),
    .fsl_err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; adr = 5'd3; tga = 2'b00; stb = 1'b0; wre = 1'b0; sel = 4'hf;
    wdat = '0; fso_rdy = 1'b0; fsi_dat = '0; fsi_ctl = 1'b0; fsi_vld = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fso_vld", {31'd0, fso_vld}, 32'd0);
    chk("rst_fsi_rdy_gated", {31'd0, fsi_rdy}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_fsi_rdy", {31'd0, fsi_rdy}, 32'd1);
    chk("post_rst_fso_vld", {31'd0, fso_vld}, 32'd0);

    // Blocking PUT DEADBEEF ctl=1, sink ready
    fso_rdy = 1'b1; stb = 1'b1; wre = 1'b1; tga = 2'b10; wdat = 32'hDEADBEEF;
    tick();
    chk("put1_ack", {31'd0, ack}, 32'd1);
    chk("put1_fso_vld", {31'd0, fso_vld}, 32'd1);
    chk("put1_fso_dat", fso_dat, 32'hDEADBEEF);
    chk("put1_fso_ctl", {31'd0, fso_ctl}, 32'd1);
    stb = 1'b0;
    tick();
    chk("put1_ack_single", {31'd0, ack}, 32'd0);
    chk("put1_drained", {31'd0, fso_vld}, 32'd0);
    fso_rdy = 1'b0;

    // Five blocking PUTs into a stalled sink
    tga = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      wdat = 32'(i); stb = 1'b1;
      tick();
      chk("fill_ack", {31'd0, ack}, 32'd1);
      stb = 1'b0;
      tick();
    end
    wdat = 32'd5; stb = 1'b1;
    tick();
    chk("put5_stall_a", {31'd0, ack}, 32'd0);
    tick();
    chk("put5_stall_b", {31'd0, ack}, 32'd0);
    chk("put5_head", fso_dat, 32'd1);
    fso_rdy = 1'b1;
    tick();
    chk("put5_not_yet", {31'd0, ack}, 32'd0);
    fso_rdy = 1'b0;
    tick();
    chk("put5_ack", {31'd0, ack}, 32'd1);
    stb = 1'b0;
    fso_rdy = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("tx_order", fso_dat, 32'(i));
      tick();
    end
    chk("tx_empty", {31'd0, fso_vld}, 32'd0);
    fso_rdy = 1'b0;

    // Blocking GET waits for an fsi word
    wre = 1'b0; tga = 2'b10; stb = 1'b1;
    tick();
    chk("bget_stall_a", {31'd0, ack}, 32'd0);
    tick();
    chk("bget_stall_b", {31'd0, ack}, 32'd0);
    fsi_vld = 1'b1; fsi_ctl = 1'b1; fsi_dat = 32'h12345678;
    tick();
    chk("bget_push_cycle", {31'd0, ack}, 32'd0);
    fsi_vld = 1'b0;
    tick();
    chk("bget_ack", {31'd0, ack}, 32'd1);
    chk("bget_dat", rdat, 32'h12345678);
    chk("bget_err", {31'd0, err}, 32'd0);
    stb = 1'b0;
    tick();

    // Control-bit mismatch
    fsi_vld = 1'b1;
    tick();
    fsi_vld = 1'b0; tga = 2'b00; stb = 1'b1;
    tick();
    chk("mis_ack", {31'd0, ack}, 32'd1);
    chk("mis_dat", rdat, 32'h12345678);
    chk("mis_err", {31'd0, err}, 32'd1);
    stb = 1'b0;
    tick();
    chk("mis_err_pulse", {31'd0, err}, 32'd0);

    // Non-blocking GET on empty
    tga = 2'b01; stb = 1'b1;
    tick();
    chk("nbget_ack", {31'd0, ack}, 32'd1);
    chk("nbget_dat", rdat, 32'd0);
    chk("nbget_err", {31'd0, err}, 32'd0);
    stb = 1'b0;
    tick();

    // Fill RX, then GET with a source pushing against a full FIFO
    fsi_vld = 1'b1; fsi_ctl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fsi_dat = 32'hA0 + 32'(i);
      tick();
    end
    chk("rx_full_rdy", {31'd0, fsi_rdy}, 32'd0);
    fsi_dat = 32'hBB; tga = 2'b00; stb = 1'b1;
    tick();
    chk("full_get_ack", {31'd0, ack}, 32'd1);
    chk("full_get_dat", rdat, 32'hA0);
    chk("full_get_rdy", {31'd0, fsi_rdy}, 32'd1);
    fsi_vld = 1'b0; stb = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tga = 2'b01; stb = 1'b1;
      tick();
      chk("drain_ack", {31'd0, ack}, 32'd1);
      chk("drain_dat", rdat, (i == 4) ? 32'd0 : 32'hA0 + 32'(i));
      stb = 1'b0;
      tick();
    end

    // Other channel is ignored
    adr = 5'd4; wre = 1'b1; tga = 2'b00; wdat = 32'h55; stb = 1'b1;
    tick(); tick();
    chk("oth_put_ack", {31'd0, ack}, 32'd0);
    chk("oth_put_fso", {31'd0, fso_vld}, 32'd0);
    wre = 1'b0; tga = 2'b01;
    tick();
    chk("oth_get_ack", {31'd0, ack}, 32'd0);
    stb = 1'b0; adr = 5'd3;
    tick();

    // Reset during a stalled GET
    wre = 1'b1; tga = 2'b00; wdat = 32'h77; stb = 1'b1;
    tick();
    chk("pre_rst_put_ack", {31'd0, ack}, 32'd1);
    stb = 1'b0;
    tick();
    chk("pre_rst_fso_vld", {31'd0, fso_vld}, 32'd1);
    wre = 1'b0; tga = 2'b00; stb = 1'b1;
    tick();
    chk("stall_get", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    tick();
    chk("in_rst_ack", {31'd0, ack}, 32'd0);
    chk("in_rst_fso_vld", {31'd0, fso_vld}, 32'd0);
    tick();
    rst = 1'b1; stb = 1'b0;
    tick();
    chk("rel_ack", {31'd0, ack}, 32'd0);
    chk("rel_fso_vld", {31'd0, fso_vld}, 32'd0);
    chk("rel_fsi_rdy", {31'd0, fsi_rdy}, 32'd1);
    tga = 2'b01; stb = 1'b1;
    tick();
    chk("rel_nbget_ack", {31'd0, ack}, 32'd1);
    chk("rel_nbget_dat", rdat, 32'd0);
    stb = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
